// File: rtl/noc_local_interface.sv
// Local-core network interface: packs core requests into single-flit packets and injects them
// with credit flow control; buffers ejected flits for the core and returns one credit per pop.
module noc_local_interface #(
  parameter int XCOORD   = 1,
  parameter int YCOORD   = 1,
  parameter int TX_DEPTH = 4,
  parameter int RX_DEPTH = 4,
  parameter int CREDITS  = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tx_valid_i,
  output logic        tx_ready_o,
  input  logic [3:0]  tx_dest_x_i,
  input  logic [3:0]  tx_dest_y_i,
  input  logic [7:0]  tx_payload_i,
  output logic [15:0] link_data_o,
  output logic        link_enable_o,
  input  logic        link_credit_i,
  input  logic [15:0] link_data_i,
  input  logic        link_enable_i,
  output logic        link_credit_o,
  output logic        rx_valid_o,
  input  logic        rx_ready_i,
  output logic [7:0]  rx_payload_o,
  output logic        rx_misroute_o,
  output logic        err_o
);

  localparam int TXA = $clog2(TX_DEPTH);
  localparam int RXA = $clog2(RX_DEPTH);
  localparam int CW  = $clog2(CREDITS + 1);

  logic [15:0]   tx_mem [TX_DEPTH];
  logic [TXA-1:0] tx_wr, tx_rd;
  logic [TXA:0]   tx_cnt;
  logic [CW-1:0]  credit_cnt;

  logic [15:0]   rx_mem [RX_DEPTH];
  logic [RXA-1:0] rx_wr, rx_rd;
  logic [RXA:0]   rx_cnt;

  logic tx_push, tx_send, rx_push, rx_pop, rx_full, rx_drop, misroute_hit, credit_ovf;

  // Ready is a function of the registered count only, so a full FIFO never takes a push.
  assign tx_ready_o = (tx_cnt != (TXA+1)'(TX_DEPTH));
  assign tx_push    = tx_valid_i && tx_ready_o;
  assign tx_send    = (tx_cnt != '0) && (credit_cnt != '0);
  assign credit_ovf = link_credit_i && !tx_send && (credit_cnt == CW'(CREDITS));

  assign rx_valid_o   = (rx_cnt != '0);
  assign rx_full      = (rx_cnt == (RXA+1)'(RX_DEPTH));
  assign rx_pop       = rx_valid_o && rx_ready_i;
  assign rx_push      = link_enable_i && (!rx_full || rx_pop);
  assign rx_drop      = link_enable_i && rx_full && !rx_pop;
  assign misroute_hit = link_enable_i &&
                        ((link_data_i[7:4] != 4'(XCOORD)) || (link_data_i[3:0] != 4'(YCOORD)));
  assign rx_payload_o = rx_valid_o ? rx_mem[rx_rd][15:8] : 8'h00;

  // Storage arrays carry no reset; validity is tracked entirely by the counts.
  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wr] <= {tx_payload_i, tx_dest_x_i, tx_dest_y_i};
    if (rx_push) rx_mem[rx_wr] <= link_data_i;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wr         <= '0;
      tx_rd         <= '0;
      tx_cnt        <= '0;
      credit_cnt    <= CW'(CREDITS);
      link_data_o   <= '0;
      link_enable_o <= 1'b0;
      rx_wr         <= '0;
      rx_rd         <= '0;
      rx_cnt        <= '0;
      link_credit_o <= 1'b0;
      rx_misroute_o <= 1'b0;
      err_o         <= 1'b0;
    end else begin
      if (tx_push) tx_wr <= tx_wr + 1'b1;
      if (tx_send) begin
        tx_rd       <= tx_rd + 1'b1;
        link_data_o <= tx_mem[tx_rd];
      end
      link_enable_o <= tx_send;
      tx_cnt <= tx_cnt + (TXA+1)'(tx_push) - (TXA+1)'(tx_send);

      case ({tx_send, link_credit_i})
        2'b10:   credit_cnt <= credit_cnt - 1'b1;
        2'b01:   if (!credit_ovf) credit_cnt <= credit_cnt + 1'b1;
        default: credit_cnt <= credit_cnt;
      endcase

      if (rx_push) rx_wr <= rx_wr + 1'b1;
      if (rx_pop)  rx_rd <= rx_rd + 1'b1;
      rx_cnt <= rx_cnt + (RXA+1)'(rx_push) - (RXA+1)'(rx_pop);
      link_credit_o <= rx_pop;

      if (misroute_hit)          rx_misroute_o <= 1'b1;
      if (rx_drop || credit_ovf) err_o         <= 1'b1;
    end
  end

endmodule
